// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem read feeding a small
// circular buffer of {pc, instr} entries for decode.
module fetch_unit #(
  parameter int BUF_DEPTH = 2,
  parameter int ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              fetch_busy
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_mem [BUF_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [BUF_DEPTH];
  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     wr_ptr_d;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              launch;
  logic              push;
  logic              pop;
  logic              head_is_new;

  // A launch only happens in IDLE, so count_q already covers anything in flight.
  assign launch = (state_q == IDLE) && !flush && (count_q != FULL);
  assign push   = (state_q == WAIT) && imem_ack && !flush;
  assign pop    = instr_valid && instr_ready && !flush;

  assign pc_en      = reset & (launch | flush);
  assign imem_req   = (state_q != IDLE);
  assign fetch_busy = (state_q != IDLE);
  assign imem_addr  = addr_q;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: if (launch) state_d = WAIT;
      state_q == WAIT: begin
        if (imem_ack)   state_d = IDLE;
        else if (flush) state_d = DROP;
      end
      state_q == DROP: if (imem_ack) state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // The entry being written becomes the head when it lands in an empty buffer.
  assign head_is_new = push && (rd_ptr_d == wr_ptr_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (launch) addr_q <= {pc_in[ADDR_W-1:2], 2'b00};
      if (push) begin
        data_mem[wr_ptr_q] <= imem_rdata;
        pc_mem[wr_ptr_q]   <= addr_q;
      end
      instr_valid <= (count_d != '0);
      if (count_d != '0) begin
        instr    <= head_is_new ? imem_rdata : data_mem[rd_ptr_d];
        instr_pc <= head_is_new ? addr_q : pc_mem[rd_ptr_d];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: PC/memory model in the bench,
// expected {pc, instr} entries queued on ack and compared at the head.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_busy;

  fetch_unit #(.BUF_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_en       (pc_en),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fetch_busy  (fetch_busy)
  );

  always #5 clock = ~clock;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] exp_q [$];
  logic [31:0] pc = '0;
  logic [31:0] tgt = '0;
  logic [31:0] launch_addr = '0;
  logic [31:0] addr_prev = '0;
  logic [31:0] ovr_data = '0;
  bit          in_flight, drop, launch_pend;
  bit          req_prev, ack_prev, ovr_en, stray;
  int          lat_cfg = 0;
  int          wait_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h13;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    in_flight   = 0;
    drop        = 0;
    launch_pend = 0;
    req_prev    = 0;
    ack_prev    = 0;
    wait_cnt    = 0;
  endtask

  task automatic step(input bit fl, input bit rdy);
    bit ack, lch, pop, push;
    @(negedge clock);
    ack = 0;
    if (stray) ack = 1;
    else if (imem_req) begin
      if (wait_cnt >= lat_cfg) ack = 1;
      else wait_cnt++;
    end
    imem_rdata  = ovr_en ? ovr_data : mem_word(imem_addr);
    imem_ack    = ack;
    flush       = fl;
    instr_ready = rdy;
    pc_in       = pc;
    #1;
    if (launch_pend) chk("launch_addr", imem_addr, launch_addr);
    if (req_prev && !ack_prev) chk("addr_hold", imem_addr, addr_prev);
    chk("imem_req", imem_req, in_flight);
    chk("fetch_busy", fetch_busy, in_flight);
    lch = !fl && !in_flight && (exp_q.size() < DEPTH);
    chk("pc_en", pc_en, fl || lch);
    chk("instr_valid", instr_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("instr_pc", instr_pc, exp_q[0][63:32]);
      chk("instr", instr, exp_q[0][31:0]);
    end
    pop  = (exp_q.size() != 0) && rdy && !fl;
    push = in_flight && ack && !fl && !drop;
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({launch_addr, imem_rdata});
    end
    if (in_flight && ack) begin
      in_flight = 0;
      drop      = 0;
      wait_cnt  = 0;
    end else if (in_flight && fl) begin
      drop = 1;
    end
    launch_pend = lch;
    if (lch) begin
      in_flight   = 1;
      launch_addr = {pc[31:2], 2'b00};
    end
    if (fl) pc = tgt;
    else if (lch) pc = pc + 32'd4;
    req_prev  = imem_req;
    ack_prev  = ack;
    addr_prev = imem_addr;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    flush       = 1'b0;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  // Returns just after a fresh launch, so the next cycle is the first WAIT.
  task automatic wait_launch();
    int n;
    n = 0;
    while (in_flight && n < 30) begin
      step(0, 1);
      n++;
    end
    while (!(in_flight && launch_pend) && n < 60) begin
      step(0, 1);
      n++;
    end
    chk("launch_timeout", n < 60, 1);
  endtask

  initial begin
    int n;
    #1 reset = 1'b0;
    #1;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_fetch_busy", fetch_busy, 0);

    // first fetch with single-cycle memory
    pc = 32'h0;
    lat_cfg = 0;
    @(posedge clock);
    #2 reset = 1'b1;
    step(0, 1);
    chk("first_addr", imem_addr, 32'h0);
    step(0, 1);
    step(0, 1);
    chk("first_instr", instr, 32'h13);
    chk("first_pc", instr_pc, 32'h0);
    step(0, 1);
    chk("second_addr", imem_addr, 32'h4);

    // fill the buffer with decode stalled
    do_reset();
    pc = 32'h0;
    repeat (8) step(0, 0);
    chk("pc_held", pc, 32'h8);
    chk("full_req", imem_req, 0);
    chk("full_pc_en", pc_en, 0);
    chk("full_valid", instr_valid, 1);
    repeat (6) step(0, 1);

    // long memory stall
    lat_cfg = 5;
    wait_launch();
    repeat (7) step(0, 1);

    // flush while waiting, late ack must be dropped
    lat_cfg = 2;
    wait_launch();
    ovr_en = 1;
    ovr_data = 32'hDEAD_BEEF;
    tgt = 32'h100;
    step(1, 1);
    chk("drop_busy", fetch_busy, 1);
    chk("flush_clear", instr_valid, 0);
    repeat (3) step(0, 1);
    ovr_en = 0;
    chk("drop_nopush", instr_valid, 0);
    step(0, 1);
    chk("redirect_addr", imem_addr, 32'h100);

    // flush coinciding with ack and pop at count 1
    lat_cfg = 0;
    n = 0;
    while (!(exp_q.size() == 1 && in_flight) && n < 30) begin
      step(0, 0);
      n++;
    end
    chk("setup_timeout", n < 30, 1);
    tgt = 32'h200;
    step(1, 1);
    step(0, 0);
    chk("flush_ack_pop", instr_valid, 0);

    // asynchronous reset in the middle of WAIT
    lat_cfg = 3;
    wait_launch();
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_pc_en", pc_en, 0);
    chk("async_valid", instr_valid, 0);
    model_reset();
    flush = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    stray = 1;
    step(0, 1);
    stray = 0;
    lat_cfg = 0;
    repeat (6) step(0, 1);

    // random traffic
    repeat (400) begin
      if (!in_flight) lat_cfg = $urandom_range(0, 3);
      tgt = $urandom;
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (10) step(0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
